// File: rtl/ssd_ahb_display.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_ahb_display
//  Function : AHB-Lite slave that stages and commits a 5-bit class index,
//             then shows it on a time-multiplexed 4-digit 7-segment display.
//  Revision : 1.0  initial release
// ============================================================================
module ssd_ahb_display #(
    parameter int          REFRESH_DIV = 100000,
    parameter logic [3:0]  BASE_HI     = 4'hC,
    parameter int          CNT_W       = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ahb_s0_haddr_i,
    input  logic        ahb_s0_hwrite_i,
    input  logic [2:0]  ahb_s0_hsize_i,
    input  logic [2:0]  ahb_s0_hburst_i,
    input  logic [3:0]  ahb_s0_hprot_i,
    input  logic [1:0]  ahb_s0_htrans_i,
    input  logic        ahb_s0_hmastlock_i,
    input  logic [31:0] ahb_s0_hwdata_i,
    input  logic        SW0,
    output logic [31:0] ahb_s0_hrdata_o,
    output logic        ahb_s0_hready_o,
    output logic        ahb_s0_hresp_o,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] c_ref_last = REF_W'(REFRESH_DIV - 1);
    localparam logic [6:0] c_blank = 7'h7F;

    typedef enum logic [0:0] {
        ST_OKAY = 1'b0,
        ST_ERR2 = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_dp_valid;
    logic [1:0]       r_dp_addr;
    logic             r_dp_write;
    logic             r_dp_size_ok;
    logic [4:0]       r_data;
    logic [4:0]       r_committed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sw_meta;
    logic             r_sw_sync;
    logic [REF_W-1:0] r_refresh;
    logic [1:0]       r_digit;

    logic             w_accept;
    logic             w_dp_err;
    logic             w_wr_en;
    logic [31:0]      w_status;
    logic [1:0]       w_digit_next;
    logic [3:0]       w_ones;
    logic [3:0]       w_tens;
    logic [6:0]       w_seg_next;
    logic [3:0]       w_an_next;

    logic w_unused;
    assign w_unused = ^{ahb_s0_hburst_i, ahb_s0_hprot_i, ahb_s0_hmastlock_i,
                        ahb_s0_haddr_i[27:4], ahb_s0_haddr_i[1:0],
                        ahb_s0_htrans_i[0], ahb_s0_hwdata_i[31:5]};

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_accept = ahb_s0_htrans_i[1] && ahb_s0_hready_o &&
                      (ahb_s0_haddr_i[31:28] == BASE_HI);
    assign w_dp_err = r_dp_valid && ((r_dp_addr == 2'd3) || !r_dp_size_ok);

    always_comb begin
        w_status                   = '0;
        w_status[4:0]              = r_committed;
        w_status[8]                = r_sw_sync;
        w_status[16+CNT_W-1:16]    = r_cnt;
    end

    // ------------------------------------------------------------------------
    // Bus response FSM: ERR1 is the erroring data phase itself, ERR2 is a state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_OKAY;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        ahb_s0_hready_o = 1'b1;
        ahb_s0_hresp_o  = 1'b0;
        ahb_s0_hrdata_o = '0;
        w_wr_en         = 1'b0;
        case (r_state)
            ST_OKAY: begin
                if (w_dp_err) begin
                    ahb_s0_hready_o = 1'b0;
                    ahb_s0_hresp_o  = 1'b1;
                    w_state_next    = ST_ERR2;
                end else if (r_dp_valid) begin
                    if (r_dp_write) begin
                        w_wr_en = 1'b1;
                    end else begin
                        case (r_dp_addr)
                            2'd0:    ahb_s0_hrdata_o = {27'd0, r_data};
                            2'd2:    ahb_s0_hrdata_o = w_status;
                            default: ahb_s0_hrdata_o = '0;
                        endcase
                    end
                end
            end
            ST_ERR2: begin
                ahb_s0_hresp_o = 1'b1;
                w_state_next   = ST_OKAY;
            end
            default: w_state_next = ST_OKAY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dp_valid   <= 1'b0;
            r_dp_addr    <= 2'd0;
            r_dp_write   <= 1'b0;
            r_dp_size_ok <= 1'b0;
        end else begin
            r_dp_valid <= w_accept;
            if (w_accept) begin
                r_dp_addr    <= ahb_s0_haddr_i[3:2];
                r_dp_write   <= ahb_s0_hwrite_i;
                r_dp_size_ok <= (ahb_s0_hsize_i == 3'b010);
            end
        end
    end

    // Commit reads r_data as already updated by a preceding pipelined write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data      <= '0;
            r_committed <= '0;
            r_cnt       <= '0;
        end else if (w_wr_en) begin
            case (r_dp_addr)
                2'd0: r_data <= ahb_s0_hwdata_i[4:0];
                2'd1: begin
                    if (ahb_s0_hwdata_i[0]) begin
                        r_committed <= r_data;
                        r_cnt       <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sw_meta <= 1'b0;
            r_sw_sync <= 1'b0;
        end else begin
            r_sw_meta <= SW0;
            r_sw_sync <= r_sw_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Display: seg/an are loaded only at slot boundaries for the next digit
    // ------------------------------------------------------------------------
    always_comb begin
        w_digit_next = r_digit + 2'd1;
        w_an_next    = ~(4'b0001 << w_digit_next);
        if (r_sw_sync) begin
            w_ones = r_committed[3:0];
            w_tens = {3'b000, r_committed[4]};
        end else begin
            w_ones = 4'(r_committed % 5'd10);
            w_tens = 4'(r_committed / 5'd10);
        end
        case (w_digit_next)
            2'd0:    w_seg_next = seg_encode(w_ones);
            2'd1:    w_seg_next = (w_tens == 4'd0) ? c_blank : seg_encode(w_tens);
            default: w_seg_next = c_blank;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_refresh <= '0;
            r_digit   <= 2'd0;
            seg       <= c_blank;
            an        <= 4'hF;
        end else if (r_refresh == c_ref_last) begin
            r_refresh <= '0;
            r_digit   <= w_digit_next;
            seg       <= w_seg_next;
            an        <= w_an_next;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

endmodule
`default_nettype wire
